// File: rtl/mult_recon.sv
// -----------------------------------------------------------------------------
// mult_recon
//
// Sequential shift-add reconstruction unit. Given the outputs of the restoring
// divider (quotient, divisor, remainder) it rebuilds the dividend:
//
//   numerador = cociente * denominador + resto      (unsigned, 2W bits)
//
// One multiplier bit is consumed per CALC cycle; the remainder seeds the
// accumulator so no separate final add is needed. The handshake mirrors the
// divider: start is sampled only in IDLE, finish is a one-cycle pulse.
//
// Optional feature (macro MULT_RECON_CHECK_EN):
//   defined   - CHECK rejects denominador == 0 and resto >= denominador;
//               a rejected operation returns all ones with error = 1.
//   undefined - CHECK always proceeds, error stays 0. The CHECK cycle is kept
//               so latency does not depend on the build.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   start        in   operation request, sampled only in IDLE
//   cociente     in   [W-1:0]   quotient (multiplier)
//   denominador  in   [W-1:0]   divisor (multiplicand)
//   resto        in   [W-1:0]   remainder (initial accumulator)
//   numerador    out  [2W-1:0]  reconstructed dividend, registered
//   error        out  invalid operands, registered
//   busy         out  high in every state except IDLE
//   finish       out  one-cycle completion pulse, registered
// -----------------------------------------------------------------------------
module mult_recon #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   cociente,
  input  logic [W-1:0]   denominador,
  input  logic [W-1:0]   resto,
  output logic [2*W-1:0] numerador,
  output logic           error,
  output logic           busy,
  output logic           finish
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    CALC,
    FIN
  } state_t;

  // Iteration counter only has to reach W-1.
  localparam int            IW     = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(W - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   mq_q, mq_d;
  logic [W-1:0]   md_q, md_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [IW-1:0]  i_q, i_d;
  logic [2*W-1:0] numerador_q, numerador_d;
  logic           error_q, error_d;
  logic           finish_q, finish_d;

  logic [2*W-1:0] addend;
  logic [2*W-1:0] acc_sum;

  // Partial product for the current multiplier bit. The shift never exceeds
  // W-1 and the result never exceeds 2^2W - 2^W, so the 2W-bit sum cannot
  // carry out.
  assign addend  = mq_q[0] ? ({{W{1'b0}}, md_q} << i_q) : '0;
  assign acc_sum = acc_q + addend;

  // NOTE: every _d gets its hold value before the case statement, so no path
  // through the case can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    mq_d        = mq_q;
    md_d        = md_q;
    acc_d       = acc_q;
    i_d         = i_q;
    numerador_d = numerador_q;
    error_d     = error_q;
    finish_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mq_d    = cociente;
          md_d    = denominador;
          acc_d   = {{W{1'b0}}, resto};
          i_d     = '0;
          error_d = 1'b0;
          state_d = CHECK;
        end
      end

      CHECK: begin
`ifdef MULT_RECON_CHECK_EN
        // A zero divisor or a remainder not below the divisor cannot have
        // come from a correct division.
        if ((md_q == '0) || (acc_q[W-1:0] >= md_q)) begin
          numerador_d = '1;
          error_d     = 1'b1;
          state_d     = FIN;
        end else begin
          state_d = CALC;
        end
`else
        state_d = CALC;
`endif
      end

      CALC: begin
        acc_d = acc_sum;
        mq_d  = mq_q >> 1;
        i_d   = i_q + 1'b1;
        if (i_q == I_LAST) begin
          numerador_d = acc_sum;
          state_d     = FIN;
        end
      end

      FIN: begin
        finish_d = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // Reset aborts an operation in flight; no finish pulse follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mq_q        <= '0;
      md_q        <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      numerador_q <= '0;
      error_q     <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mq_q        <= mq_d;
      md_q        <= md_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      numerador_q <= numerador_d;
      error_q     <= error_d;
      finish_q    <= finish_d;
    end
  end

  assign numerador = numerador_q;
  assign error     = error_q;
  assign finish    = finish_q;
  assign busy      = (state_q != IDLE);

endmodule
